// File: rtl/multi_cycle_alu.sv
// multi_cycle_alu: small ALU with a valid/ready request side and a valid/ready
// result side.
// AND, OR, ADD, SUB, XOR and SLT finish in one cycle.
// SLL shifts one bit per BUSY cycle.
// MUL is a shift-add multiplier that runs for WIDTH BUSY cycles.
// Build option: define ALU_MUL_EN to include the multiplier.
// Without ALU_MUL_EN, ctrl = 7 completes in one cycle with a zero result.
//
// Handshake: a request is accepted on a rising edge where in_valid && in_ready
// (in_ready is high only in IDLE). A result is taken on a rising edge where
// out_valid && out_ready (out_valid is high only in DONE). Neither side may
// assume the other is ready; in_valid is ignored outside IDLE.
module multi_cycle_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       dbg_state
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;

    state_t           w_state_nxt;
    logic [2:0]       w_op_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_zero_nxt;
    logic             w_accept;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH-1:0] w_quick;
    logic [WIDTH-1:0] w_step;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] w_mul_add;
`endif

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_amt     = in_2[SHW-1:0];
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign zero      = r_zero;
    assign dbg_state = r_state;

`ifdef ALU_MUL_EN
    // Partial product for the current multiplier bit.
    assign w_mul_add = r_b[0] ? r_a : '0;
`endif

    // Single-cycle results, computed straight from the request inputs.
    // SLL by zero and MUL without the multiplier land here as well.
    always_comb begin
        w_quick = '0;
        case (ctrl)
            OP_AND:  w_quick = in_1 & in_2;
            OP_OR:   w_quick = in_1 | in_2;
            OP_ADD:  w_quick = in_1 + in_2;
            OP_SUB:  w_quick = in_1 - in_2;
            OP_XOR:  w_quick = in_1 ^ in_2;
            OP_SLT:  w_quick = {{(WIDTH-1){1'b0}}, ($signed(in_1) < $signed(in_2))};
            OP_SLL:  w_quick = in_1;
            default: w_quick = '0;
        endcase
    end

    // One BUSY step: shift for SLL, shift-add for MUL.
    always_comb begin
        w_step = r_acc;
        if (r_op == OP_SLL) begin
            w_step = r_acc << 1;
        end
`ifdef ALU_MUL_EN
        else begin
            w_step = r_acc + w_mul_add;
        end
`endif
    end

    // Next-state and datapath-load decisions for the IDLE/BUSY/DONE controller.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_zero_nxt  = r_zero;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_op_nxt  = ctrl;
                    w_a_nxt   = in_1;
                    w_b_nxt   = in_2;
                    w_acc_nxt = '0;
                    if ((ctrl == OP_SLL) && (w_amt != '0)) begin
                        w_acc_nxt   = in_1;
                        w_cnt_nxt   = {1'b0, w_amt};
                        w_state_nxt = S_BUSY;
                    end
`ifdef ALU_MUL_EN
                    else if (ctrl == OP_MUL) begin
                        w_cnt_nxt   = CW'(WIDTH);
                        w_state_nxt = S_BUSY;
                    end
`endif
                    else begin
                        w_out_nxt   = w_quick;
                        w_zero_nxt  = (w_quick == '0);
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                w_acc_nxt = w_step;
                w_cnt_nxt = r_cnt - CW'(1);
`ifdef ALU_MUL_EN
                if (r_op == OP_MUL) begin
                    w_a_nxt = r_a << 1;
                    w_b_nxt = r_b >> 1;
                end
`endif
                if (r_cnt == CW'(1)) begin
                    w_out_nxt   = w_step;
                    w_zero_nxt  = (w_step == '0);
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_zero  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_zero  <= w_zero_nxt;
        end
    end

endmodule
